// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        IDLE     = 3'd1,
        SETUP    = 3'd2,
        PULSE    = 3'd3,
        HOLD     = 3'd4,
        WAIT     = 3'd5
    } lcd_state_e;

    localparam int unsigned BYTE_LSB = 0;
    localparam int unsigned BYTE_MSB = 7;
    localparam int unsigned RS_BIT   = 8;
    localparam int unsigned REQ_BIT  = 9;
    localparam int unsigned BLON_BIT = 30;
    localparam int unsigned ON_BIT   = 31;

    // Power-up command sequence, entry 0 first: function set, display on, clear, entry mode.
    localparam logic [3:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

    // Clear and return-home take far longer to execute than any other command.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] cmd);
        return (rs == 1'b0) && (cmd >= 8'h01) && (cmd <= 8'h03);
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter; done is high once the count has reached zero.
module lcd_delay_cnt #(
    parameter int unsigned     W       = 8,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_r;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= RST_VAL;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Write-only HD44780 controller: power-up init, then one timed bus write per toggle request.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned PWR_CYC   = 750_000,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 12,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned EXEC_CYC  = 2_000,
    parameter int unsigned CLR_CYC   = 82_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] io_lcd_i,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic        lcd_on_o,
    output logic        lcd_blon_o,
    output logic        lcd_busy_o
);

    localparam int unsigned MAX_01  = (PWR_CYC > SETUP_CYC) ? PWR_CYC : SETUP_CYC;
    localparam int unsigned MAX_23  = (PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC;
    localparam int unsigned MAX_45  = (EXEC_CYC > CLR_CYC) ? EXEC_CYC : CLR_CYC;
    localparam int unsigned MAX_A   = (MAX_01 > MAX_23) ? MAX_01 : MAX_23;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_45) ? MAX_A : MAX_45;
    localparam int unsigned CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    // The counter holds N-1 so that a state loaded with it lasts exactly N cycles.
    localparam logic [CNT_W-1:0] PWR_LOAD   = CNT_W'(PWR_CYC - 32'd1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 32'd1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 32'd1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 32'd1);
    localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(EXEC_CYC - 32'd1);
    localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(CLR_CYC - 32'd1);

    lcd_state_e       state_r, state_s;
    logic             ack_tgl_r, ack_tgl_s;
    logic [7:0]       data_r, data_s;
    logic             rs_r, rs_s;
    logic             init_act_r, init_act_s;
    logic [1:0]       init_idx_r, init_idx_s;
    logic             en_r, on_r, blon_r, busy_r;
    logic             pend_s;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic             cnt_done_s;
    logic             unused_s;

    assign pend_s   = io_lcd_i[REQ_BIT] ^ ack_tgl_r;
    assign unused_s = ^io_lcd_i[29:10];

    lcd_delay_cnt #(
        .W       (CNT_W),
        .RST_VAL (PWR_LOAD)
    ) u_delay (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load     (load_s),
        .load_val (load_val_s),
        .done     (cnt_done_s)
    );

    // Next-state, request acceptance and init sequencing.
    always_comb begin
        state_s    = state_r;
        ack_tgl_s  = ack_tgl_r;
        data_s     = data_r;
        rs_s       = rs_r;
        init_act_s = init_act_r;
        init_idx_s = init_idx_r;
        case (state_r)
            PWR_WAIT: begin
                if (cnt_done_s) begin
                    state_s    = SETUP;
                    init_act_s = 1'b1;
                    init_idx_s = 2'd0;
                    data_s     = INIT_ROM[0];
                    rs_s       = 1'b0;
                end else begin
                    state_s = PWR_WAIT;
                end
            end
            IDLE: begin
                if (pend_s) begin
                    state_s   = SETUP;
                    ack_tgl_s = io_lcd_i[REQ_BIT];
                    data_s    = io_lcd_i[BYTE_MSB:BYTE_LSB];
                    rs_s      = io_lcd_i[RS_BIT];
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (cnt_done_s) state_s = PULSE;
                else            state_s = SETUP;
            end
            PULSE: begin
                if (cnt_done_s) state_s = HOLD;
                else            state_s = PULSE;
            end
            HOLD: begin
                if (cnt_done_s) state_s = WAIT;
                else            state_s = HOLD;
            end
            WAIT: begin
                if (!cnt_done_s) begin
                    state_s = WAIT;
                end else if (init_act_r && (init_idx_r != 2'd3)) begin
                    state_s    = SETUP;
                    init_idx_s = init_idx_r + 2'd1;
                    data_s     = INIT_ROM[init_idx_r + 2'd1];
                    rs_s       = 1'b0;
                end else begin
                    state_s    = IDLE;
                    init_act_s = 1'b0;
                end
            end
            default: begin
                state_s    = PWR_WAIT;
                init_act_s = 1'b0;
                init_idx_s = 2'd0;
            end
        endcase
    end

    // Delay for the state being entered; the wait length follows the command just sent.
    always_comb begin
        load_val_s = '0;
        case (state_s)
            PWR_WAIT: load_val_s = PWR_LOAD;
            SETUP:    load_val_s = SETUP_LOAD;
            PULSE:    load_val_s = PULSE_LOAD;
            HOLD:     load_val_s = HOLD_LOAD;
            WAIT: begin
                if (is_long_cmd(rs_r, data_r)) load_val_s = CLR_LOAD;
                else                           load_val_s = EXEC_LOAD;
            end
            default:  load_val_s = '0;
        endcase
    end

    assign load_s = (state_s != state_r);

    // State, handshake and all output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= PWR_WAIT;
            ack_tgl_r  <= 1'b0;
            data_r     <= 8'h00;
            rs_r       <= 1'b0;
            init_act_r <= 1'b0;
            init_idx_r <= 2'd0;
            en_r       <= 1'b0;
            on_r       <= 1'b0;
            blon_r     <= 1'b0;
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_s;
            ack_tgl_r  <= ack_tgl_s;
            data_r     <= data_s;
            rs_r       <= rs_s;
            init_act_r <= init_act_s;
            init_idx_r <= init_idx_s;
            en_r       <= (state_s == PULSE);
            on_r       <= io_lcd_i[ON_BIT];
            blon_r     <= io_lcd_i[BLON_BIT];
            busy_r     <= (state_s != IDLE) | (io_lcd_i[REQ_BIT] ^ ack_tgl_s);
        end
    end

    assign lcd_data_o = data_r;
    assign lcd_rs_o   = rs_r;
    assign lcd_rw_o   = 1'b0;
    assign lcd_en_o   = en_r;
    assign lcd_on_o   = on_r;
    assign lcd_blon_o = blon_r;
    assign lcd_busy_o = busy_r;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: timing-window reference model plus directed and random stimulus.
module tb_lcd_ctrl;

    localparam int PWR = 10;
    localparam int SU  = 1;
    localparam int PW  = 2;
    localparam int HD  = 1;
    localparam int EX  = 5;
    localparam int CL  = 20;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] io_lcd = 32'h0;
    logic [7:0]  lcd_data_o;
    logic        lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_blon_o, lcd_busy_o;

    lcd_ctrl #(
        .PWR_CYC   (PWR),
        .SETUP_CYC (SU),
        .PULSE_CYC (PW),
        .HOLD_CYC  (HD),
        .EXEC_CYC  (EX),
        .CLR_CYC   (CL)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .io_lcd_i   (io_lcd),
        .lcd_data_o (lcd_data_o),
        .lcd_rs_o   (lcd_rs_o),
        .lcd_rw_o   (lcd_rw_o),
        .lcd_en_o   (lcd_en_o),
        .lcd_on_o   (lcd_on_o),
        .lcd_blon_o (lcd_blon_o),
        .lcd_busy_o (lcd_busy_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    // Reference model: each transaction is a time window starting at the edge it is accepted.
    int         m_e, m_free, m_left, m_txt;
    bit         m_txv, m_ack, m_rs, m_busy, m_on, m_blon, m_en;
    logic [7:0] m_data;
    logic [31:0] io_s;

    function automatic int wait_len(input bit rs, input logic [7:0] b);
        return (!rs && b >= 8'h01 && b <= 8'h03) ? CL : EX;
    endfunction

    task automatic start_tx(input logic [7:0] b, input bit rs);
        m_data = b;
        m_rs   = rs;
        m_txv  = 1'b1;
        m_txt  = m_e;
        m_free = m_e + SU + PW + HD + wait_len(rs, b);
    endtask

    // Bus monitor results.
    logic [7:0] q_data[$];
    logic       q_rs[$];
    int         q_w[$];
    bit         en_prev = 1'b0;
    bit         fall_seen = 1'b0;
    int         pw_cnt = 0, run = 0, last_run = 0, busy_hi = 0, fall_edge = 0;

    // Advance the model at each edge, then compare the DUT and record bus activity.
    always begin
        @(posedge clk_i);
        if (!rst_ni) begin
            m_e = 0; m_free = PWR; m_left = 4; m_ack = 1'b0; m_txv = 1'b0; m_txt = 0;
            m_data = 8'h00; m_rs = 1'b0; m_on = 1'b0; m_blon = 1'b0; m_busy = 1'b1;
        end else begin
            io_s = io_lcd;
            m_e++;
            m_on   = io_s[31];
            m_blon = io_s[30];
            if (m_left > 0 && m_e == m_free) begin
                start_tx(init_seq[4 - m_left], 1'b0);
                m_left--;
            end else if (m_left == 0 && m_e > m_free && io_s[9] != m_ack) begin
                m_ack = io_s[9];
                start_tx(io_s[7:0], io_s[8]);
            end
            m_busy = (m_left != 0) || (m_e < m_free) || (io_s[9] != m_ack);
        end
        m_en = rst_ni && m_txv && (m_e >= m_txt + SU) && (m_e < m_txt + SU + PW);
        #1;
        chk("en",   32'(lcd_en_o),   32'(m_en));
        chk("busy", 32'(lcd_busy_o), 32'(m_busy));
        chk("data", 32'(lcd_data_o), 32'(m_data));
        chk("rs",   32'(lcd_rs_o),   32'(m_rs));
        chk("on",   32'(lcd_on_o),   32'(m_on));
        chk("blon", 32'(lcd_blon_o), 32'(m_blon));
        chk("rw",   32'(lcd_rw_o),   32'(1'b0));
        if (!rst_ni) begin
            en_prev = 1'b0; pw_cnt = 0; run = 0; fall_seen = 1'b0;
        end else begin
            if (lcd_en_o) begin
                if (!en_prev) begin
                    q_data.push_back(lcd_data_o);
                    q_rs.push_back(lcd_rs_o);
                end
                pw_cnt++;
            end else if (en_prev) begin
                q_w.push_back(pw_cnt);
                pw_cnt = 0;
            end
            en_prev = lcd_en_o;
            if (lcd_busy_o) begin
                run++;
                busy_hi++;
            end else begin
                if (run > 0) last_run = run;
                run = 0;
                if (!fall_seen) begin
                    fall_seen = 1'b1;
                    fall_edge = m_e;
                end
            end
        end
    end

    task automatic clear_mon();
        q_data.delete();
        q_rs.delete();
        q_w.delete();
        busy_hi  = 0;
        last_run = 0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        repeat (2) @(negedge clk_i);
        while (lcd_busy_o && n < max_cyc) begin
            @(negedge clk_i);
            n++;
        end
        chk("wait_idle", 32'(lcd_busy_o), 32'(1'b0));
    endtask

    task automatic chk_pulses(input string name, input int n, input logic [7:0] d0,
                              input logic r0, input logic [7:0] d1, input logic r1);
        chk({name, "_count"}, 32'(q_data.size()), 32'(n));
        if (q_data.size() >= 1 && q_w.size() >= 1) begin
            chk({name, "_data0"}, 32'(q_data[0]), 32'(d0));
            chk({name, "_rs0"},   32'(q_rs[0]),   32'(r0));
            chk({name, "_w0"},    32'(q_w[0]),    32'(PW));
        end
        if (n == 2 && q_data.size() >= 2 && q_w.size() >= 2) begin
            chk({name, "_data1"}, 32'(q_data[1]), 32'(d1));
            chk({name, "_rs1"},   32'(q_rs[1]),   32'(r1));
        end
    endtask

    task automatic check_init();
        chk("init_busy_fall_edge", 32'(fall_edge), 32'd61);
        chk("init_model_end",      32'(m_free),    32'd61);
        chk("init_pulse_count",    32'(q_data.size()), 32'd4);
        if (q_data.size() == 4 && q_w.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("init_data",  32'(q_data[k]), 32'(init_seq[k]));
                chk("init_rs",    32'(q_rs[k]),   32'd0);
                chk("init_width", 32'(q_w[k]),    32'd2);
            end
        end
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        int n;
        int r;
        logic [31:0] v;

        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_data", 32'(lcd_data_o), 32'h0);
        chk("rst_en",   32'(lcd_en_o),   32'h0);
        chk("rst_busy", 32'(lcd_busy_o), 32'h1);
        chk("rst_on",   32'(lcd_on_o),   32'h0);

        @(negedge clk_i);
        rst_ni = 1'b1;
        clear_mon();
        wait_idle(200);
        check_init();

        @(negedge clk_i);
        clear_mon();
        io_lcd = 32'h8000_0341;
        wait_idle(100);
        chk("char_busy_len", 32'(last_run), 32'd9);
        chk_pulses("char", 1, 8'h41, 1'b1, 8'h00, 1'b0);
        chk("char_on", 32'(lcd_on_o), 32'd1);

        clear_mon();
        io_lcd = 32'h8000_0001;
        wait_idle(100);
        chk("clear_busy_len", 32'(last_run), 32'd24);
        chk_pulses("clear", 1, 8'h01, 1'b0, 8'h00, 1'b0);

        clear_mon();
        io_lcd = 32'h8000_0341;
        repeat (3) @(negedge clk_i);
        io_lcd = 32'h8000_0142;
        wait_idle(200);
        chk("b2b_busy_len", 32'(last_run), 32'd19);
        chk_pulses("b2b", 2, 8'h41, 1'b1, 8'h42, 1'b1);

        clear_mon();
        io_lcd = 32'h8000_0241;
        repeat (2) @(negedge clk_i);
        io_lcd = 32'h0000_0055;
        repeat (2) @(negedge clk_i);
        io_lcd = 32'h8000_0241;
        wait_idle(200);
        chk("dbl_busy_len", 32'(last_run), 32'd9);
        chk_pulses("dbl", 1, 8'h41, 1'b0, 8'h00, 1'b0);

        clear_mon();
        io_lcd = 32'h8000_0041;
        n = 0;
        @(negedge clk_i);
        while (!lcd_en_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("midpulse_en_seen", 32'(lcd_en_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("midpulse_en_async",   32'(lcd_en_o),   32'd0);
        chk("midpulse_busy_async", 32'(lcd_busy_o), 32'd1);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        clear_mon();
        wait_idle(200);
        check_init();

        clear_mon();
        repeat (50) begin
            @(negedge clk_i);
            io_lcd = 32'h8000_0041;
        end
        chk("nochange_busy_cycles", 32'(busy_hi), 32'd0);
        chk("nochange_pulses",      32'(q_data.size()), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            r = int'($urandom_range(0, 31));
            v = io_lcd;
            if (r <= 1) begin
                v[9]   = ~v[9];
                v[7:0] = 8'($urandom);
                v[8]   = 1'($urandom);
            end else if (r == 2) begin
                v[9]   = ~v[9];
                v[8]   = 1'b0;
                v[7:0] = 8'($urandom_range(1, 3));
            end else if (r == 3) begin
                v[8:0] = 9'($urandom);
            end else if (r == 4) begin
                v[31:30] = 2'($urandom);
                v[29:10] = 20'($urandom);
            end
            io_lcd = v;
            if (i == 1500) begin
                rst_ni = 1'b0;
                repeat (2) @(negedge clk_i);
                rst_ni = 1'b1;
            end
        end
        wait_idle(500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
